limiter: RTL and testbench
==========================

# limiter

Sample-rate soft-knee / hard-clip limiter for the 12-bit signed audio effects chain. On each `ready` strobe it captures one sample, compresses the portion above a selectable knee by 2:1 and clamps the result to a selectable ceiling. It registers the result and pulses `done`. It sits between the sample source (ADC/filter stage) and downstream effects or DAC, all on the system clock.

## Interface
- No parameters.
- `clock` in 1 — system clock; all logic on rising edge.
- `reset` in 1 — asynchronous, active-low; clears all state.
- `ready` in 1 — one-cycle strobe: `incoming_sample` and `limiting_amount` are valid this cycle.
- `incoming_sample` in 12 — signed two's-complement input sample.
- `limiting_amount` in 2 — limiter setting:
  - 00 bypass.
  - 01 knee K=512, ceiling T=1023.
  - 10 K=256, T=511.
  - 11 K=128, T=255.
- `modified_sample` out 12 — signed limited sample; held between updates.
- `done` out 1 — one-cycle pulse when `modified_sample` updates.

## Operation
- Stage 1, on a cycle with `ready`=1:
  - Register the sample and the setting.
  - Compute magnitude `m` = |x| as a 13-bit unsigned value, so that −2048 gives 2048.
  - Register the sign bit.
- Stage 2, one cycle later, compute the limited magnitude:
  - Bypass (00): output = the captured sample unchanged, including −2048.
  - Else if m ≤ K: out_mag = m.
  - Else: out_mag = K + ((m − K) >> 1), a logical shift that truncates toward zero.
  - Then out_mag = min(out_mag, T).
- Restore the sign: y = sign ? −out_mag : out_mag. The result always fits in 12 bits because T ≤ 1023.
- Transfer is symmetric: f(−x) = −f(x) for every x > −2048.
- Transfer is monotonic non-decreasing in x for each setting.
- No state persists across samples apart from the output register. There is no envelope and no attack/release.
- `limiting_amount` is sampled only together with `ready`. Changes at other times have no effect on an in-flight sample.

## Timing
- Reset (`reset`=0, asynchronous): `modified_sample`=0, `done`=0, pipeline valid flags=0. Outputs stay at these values until the first post-reset result.
- Latency: `ready` high at edge N → `modified_sample` updated and `done`=1 after edge N+2. `done` lasts exactly one cycle.
- Throughput: one sample per clock. Back-to-back `ready` pulses on consecutive cycles yield consecutive `done` pulses with results in order.
- Without `ready`: no `done`, and `modified_sample` holds its last value indefinitely.
- Reset asserted mid-pipeline: in-flight samples are discarded and no `done` is produced for them. The first `ready` after release behaves normally.
- `ready` held high continuously: one sample is captured every cycle, and each capture is treated as an independent sample.

## Test plan
- Reset then idle: deassert `reset`, no `ready` for 100 cycles → `modified_sample`=0, `done` never asserted.
- Setting 01:
  - x=300 → 300.
  - x=800 → 656.
  - x=2000 → 1023.
  - x=−800 → −656.
  - x=−2048 → −1023.
  - Each result has `done` exactly 2 cycles after its `ready`.
- Setting 11:
  - x=200 → 164.
  - x=129 → 128.
  - x=1000 → 255.
  - x=−1000 → −255.
- Bypass (00): x=−2048 → −2048; x=2047 → 2047; x=5 → 5.
- Streaming: `ready` asserted every cycle with setting 10 and x = 0, 256, 258, 767, 1500 → outputs 0, 256, 257, 511, 511 on 5 consecutive `done` cycles.
  - Then repeat with `ready` every 64 cycles using a 1 kHz + 5 kHz sine mix. Check the outputs against a reference model, check |y| ≤ 1023 under setting 01, and check that `done` is spaced 64 cycles apart.
- Reset mid-operation: assert `ready` with x=2000, then pull `reset` low one cycle later → no `done`, `modified_sample`=0.
  - After release, x=100 → 100 with `done` 2 cycles after `ready`.

Source files
------------

// File: rtl/limiter.sv
// Three-register-stage soft-knee (2:1 above knee) and hard-clip limiter for 12-bit signed samples.
// Capture and magnitude, then the limited magnitude, then sign restore into the held output register.
module limiter (
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    input  logic signed [11:0] incoming_sample,
    input  logic        [1:0]  limiting_amount,
    output logic signed [11:0] modified_sample,
    output logic               done
);

    logic        [12:0] sampleExt;
    logic        [12:0] mag_d;

    logic               s1Valid_q;
    logic signed [11:0] s1Sample_q;
    logic        [1:0]  s1Setting_q;
    logic        [12:0] s1Mag_q;
    logic               s1Sign_q;

    logic        [9:0]  knee;
    logic        [9:0]  ceiling;
    logic        [12:0] kneeWide;
    logic        [12:0] compMag;
    logic        [9:0]  limMag_d;

    logic               s2Valid_q;
    logic               s2Bypass_q;
    logic signed [11:0] s2Sample_q;
    logic        [9:0]  s2Mag_q;
    logic               s2Sign_q;

    logic        [11:0] outMag;
    logic signed [11:0] result_d;
    logic signed [11:0] result_q;
    logic               done_q;

    // 13-bit magnitude so that -2048 maps to +2048 instead of wrapping
    always_comb begin
        sampleExt = {incoming_sample[11], incoming_sample};
        mag_d     = incoming_sample[11] ? (~sampleExt + 13'd1) : sampleExt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1Valid_q   <= 1'b0;
            s1Sample_q  <= '0;
            s1Setting_q <= '0;
            s1Mag_q     <= '0;
            s1Sign_q    <= 1'b0;
        end else begin
            s1Valid_q <= ready;
            if (ready) begin
                s1Sample_q  <= incoming_sample;
                s1Setting_q <= limiting_amount;
                s1Mag_q     <= mag_d;
                s1Sign_q    <= incoming_sample[11];
            end
        end
    end

    always_comb begin
        knee    = 10'd0;
        ceiling = 10'd0;
        case (s1Setting_q)
            2'b01:   begin knee = 10'd512; ceiling = 10'd1023; end
            2'b10:   begin knee = 10'd256; ceiling = 10'd511;  end
            2'b11:   begin knee = 10'd128; ceiling = 10'd255;  end
            default: begin knee = 10'd0;   ceiling = 10'd0;    end
        endcase
        kneeWide = {3'b000, knee};
        if (s1Mag_q <= kneeWide) begin
            compMag = s1Mag_q;
        end else begin
            compMag = kneeWide + ((s1Mag_q - kneeWide) >> 1);
        end
        // Ceiling never exceeds 1023, so the clipped magnitude fits in 10 bits
        limMag_d = (compMag > {3'b000, ceiling}) ? ceiling : compMag[9:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2Valid_q  <= 1'b0;
            s2Bypass_q <= 1'b0;
            s2Sample_q <= '0;
            s2Mag_q    <= '0;
            s2Sign_q   <= 1'b0;
        end else begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Bypass_q <= (s1Setting_q == 2'b00);
                s2Sample_q <= s1Sample_q;
                s2Mag_q    <= limMag_d;
                s2Sign_q   <= s1Sign_q;
            end
        end
    end

    always_comb begin
        outMag = {2'b00, s2Mag_q};
        if (s2Bypass_q) begin
            result_d = s2Sample_q;
        end else if (s2Sign_q) begin
            result_d = -outMag;
        end else begin
            result_d = outMag;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= s2Valid_q;
            if (s2Valid_q) begin
                result_q <= result_d;
            end
        end
    end

    assign modified_sample = result_q;
    assign done            = done_q;

endmodule

// File: tb/tb_limiter.sv
// Directed-vector bench for limiter: hand-computed results, latency, streaming order,
// a sine-mix run against a small reference model, and reset in the middle of a sample.
module tb_limiter;

    logic               clock;
    logic               reset;
    logic               ready;
    logic signed [11:0] incomingSample;
    logic        [1:0]  limitingAmount;
    logic signed [11:0] modifiedSample;
    logic               done;

    int compared   = 0;
    int mismatched = 0;
    int cycleCnt   = 0;

    limiter dut (
        .clock           (clock),
        .reset           (reset),
        .ready           (ready),
        .incoming_sample (incomingSample),
        .limiting_amount (limitingAmount),
        .modified_sample (modifiedSample),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Independent reference of the transfer curve
    function automatic int limitModel(input int x, input int setting);
        int k;
        int t;
        int m;
        int o;
        if (setting == 0) return x;
        k = (setting == 1) ? 512 : (setting == 2) ? 256 : 128;
        t = (setting == 1) ? 1023 : (setting == 2) ? 511 : 255;
        m = (x < 0) ? -x : x;
        o = (m > k) ? k + (m - k) / 2 : m;
        if (o > t) o = t;
        return (x < 0) ? -o : o;
    endfunction

    // One isolated sample: checks done timing (only after the second edge past capture) and the value
    task automatic applyStimulus(input string tag, input int x, input int setting, input int expected);
        @(negedge clock);
        ready          = 1'b1;
        incomingSample = 12'(x);
        limitingAmount = 2'(setting);
        @(negedge clock);
        ready = 1'b0;
        checkOutput({tag, " done@N"}, int'(done), 0);
        @(negedge clock);
        checkOutput({tag, " done@N+1"}, int'(done), 0);
        @(negedge clock);
        checkOutput({tag, " done@N+2"}, int'(done), 1);
        checkOutput({tag, " value"}, int'(modifiedSample), expected);
        @(negedge clock);
        checkOutput({tag, " done width"}, int'(done), 0);
    endtask

    initial begin
        int doneCount;
        int streamVals[$];
        int streamCycles[$];
        int xs[5];
        int ys[5];
        int prevDoneAt;
        int doneAt;
        int gotVal;
        int x;
        real ph;

        reset          = 1'b0;
        ready          = 1'b0;
        incomingSample = '0;
        limitingAmount = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset value", int'(modifiedSample), 0);
        checkOutput("reset done", int'(done), 0);

        reset     = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("idle done count", doneCount, 0);
        checkOutput("idle value", int'(modifiedSample), 0);

        applyStimulus("s01 x=300",   300,   1, 300);
        applyStimulus("s01 x=800",   800,   1, 656);
        applyStimulus("s01 x=2000",  2000,  1, 1023);
        applyStimulus("s01 x=-800",  -800,  1, -656);
        applyStimulus("s01 x=-2048", -2048, 1, -1023);

        applyStimulus("s11 x=200",   200,   3, 164);
        applyStimulus("s11 x=129",   129,   3, 128);
        applyStimulus("s11 x=1000",  1000,  3, 255);
        applyStimulus("s11 x=-1000", -1000, 3, -255);

        applyStimulus("byp x=-2048", -2048, 0, -2048);
        applyStimulus("byp x=2047",  2047,  0, 2047);
        applyStimulus("byp x=5",     5,     0, 5);

        repeat (20) @(negedge clock);
        checkOutput("hold value", int'(modifiedSample), 5);
        checkOutput("hold done", int'(done), 0);

        // Back-to-back strobes, setting 10
        xs = '{0, 256, 258, 767, 1500};
        ys = '{0, 256, 257, 511, 511};
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done) begin
                streamVals.push_back(int'(modifiedSample));
                streamCycles.push_back(c);
            end
            if (c < 5) begin
                ready          = 1'b1;
                incomingSample = 12'(xs[c]);
                limitingAmount = 2'b10;
            end else begin
                ready = 1'b0;
            end
        end
        checkOutput("stream done count", streamVals.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < streamVals.size()) begin
                checkOutput($sformatf("stream val%0d", i), streamVals[i], ys[i]);
                checkOutput($sformatf("stream cycle%0d", i), streamCycles[i], 3 + i);
            end
        end

        // Sine mix, one strobe every 64 cycles, setting 01
        prevDoneAt = -1;
        for (int n = 0; n < 16; n++) begin
            ph = 6.283185307179586 * real'(n) / 48.0;
            x  = int'(1000.0 * $sin(ph) + 800.0 * $sin(5.0 * ph));
            @(negedge clock);
            ready          = 1'b1;
            incomingSample = 12'(x);
            limitingAmount = 2'b01;
            doneCount = 0;
            doneAt    = -1;
            gotVal    = 0;
            for (int k = 1; k < 64; k++) begin
                @(negedge clock);
                if (k == 1) ready = 1'b0;
                if (done) begin
                    doneCount++;
                    doneAt = cycleCnt;
                    gotVal = int'(modifiedSample);
                end
            end
            checkOutput($sformatf("sine%0d done count", n), doneCount, 1);
            checkOutput($sformatf("sine%0d value", n), gotVal, limitModel(x, 1));
            checkOutput($sformatf("sine%0d within ceiling", n),
                        int'(gotVal <= 1023 && gotVal >= -1023), 1);
            if (n > 0 && prevDoneAt >= 0) begin
                checkOutput($sformatf("sine%0d spacing", n), doneAt - prevDoneAt, 64);
            end
            prevDoneAt = doneAt;
        end

        // Reset while a sample is in flight
        @(negedge clock);
        ready          = 1'b1;
        incomingSample = 12'sd2000;
        limitingAmount = 2'b01;
        @(negedge clock);
        ready = 1'b0;
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("midreset done count", doneCount, 0);
        checkOutput("midreset value", int'(modifiedSample), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("postreset idle done", int'(done), 0);
        applyStimulus("postreset x=100", 100, 1, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
